// File: rtl/pll_debug_counter_pkg.sv
// Shared constants and helpers for the emulated HFOSC->PLL->div2 clock chain.
// NUM/DEN mirror the SB_PLL40_CORE output ratio (DIVF+1)/((DIVR+1) << DIVQ).
package pll_debug_counter_pkg;

    localparam int unsigned DEF_DIVR   = 2;
    localparam int unsigned DEF_DIVF   = 63;
    localparam int unsigned DEF_DIVQ   = 6;
    localparam int unsigned LOCK_CNT_W = 8;

    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned pll_num(input int unsigned divf);
        return divf + 1;
    endfunction

    function automatic int unsigned pll_den(input int unsigned divr, input int unsigned divq);
        return (divr + 1) << divq;
    endfunction

endpackage

// File: rtl/pll_debug_counter_rate_accum.sv
// Lock-delay counter plus fractional NUM/DEN accumulator; pll_tick is a
// one-cycle enable at the emulated PLL output rate.
module rate_accum
    import pll_debug_counter_pkg::*;
#(
    parameter int unsigned NUM         = 64,
    parameter int unsigned DEN         = 192,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic pll_lock,
    output logic pll_tick
);

    localparam int unsigned ACC_W = clog2_u(DEN) + 1;
    localparam logic [ACC_W:0] NUM_W = (ACC_W + 1)'(NUM);
    localparam logic [ACC_W:0] DEN_W = (ACC_W + 1)'(DEN);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);

    if (NUM > DEN) begin : g_bad_ratio
        $error("rate_accum: NUM (%0d) must not exceed DEN (%0d)", NUM, DEN);
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_lock
        $error("rate_accum: LOCK_CYCLES (%0d) must be in 1..255", LOCK_CYCLES);
    end

    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  lock_q, lock_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  tick_q, tick_d;
    logic [ACC_W:0]        sum;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        acc_d      = acc_q;
        tick_d     = 1'b0;
        sum        = {1'b0, acc_q} + NUM_W;

        // counter stops once locked so it can never wrap and drop lock
        if (!lock_q) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
            lock_d     = (lock_cnt_q == LOCK_LAST);
        end

        if (lock_q && en) begin
            if (sum >= DEN_W) begin
                acc_d  = ACC_W'(sum - DEN_W);
                tick_d = 1'b1;
            end else begin
                acc_d  = ACC_W'(sum);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            acc_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
            acc_q      <= acc_d;
            tick_q     <= tick_d;
        end
    end

    assign pll_lock = lock_q;
    assign pll_tick = tick_q;

endmodule

// File: rtl/pll_debug_counter.sv
// Emulated oscillator->PLL->div2 chain on clk, driving a prescaled LED counter.
// Everything runs on clk; the derived clocks exist only as enable pulses.
module pll_debug_counter
    import pll_debug_counter_pkg::*;
#(
    parameter int unsigned DIVR        = DEF_DIVR,
    parameter int unsigned DIVF        = DEF_DIVF,
    parameter int unsigned DIVQ        = DEF_DIVQ,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned PRESCALE_W  = 23,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pll_lock,
    output logic             pll_tick,
    output logic             sck_tick,
    output logic [CNT_W-1:0] led
);

    localparam int unsigned NUM = pll_num(DIVF);
    localparam int unsigned DEN = pll_den(DIVR, DIVQ);

    rate_accum #(
        .NUM         (NUM),
        .DEN         (DEN),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_rate_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .pll_lock (pll_lock),
        .pll_tick (pll_tick)
    );

    logic                  phase_q, phase_d;
    logic                  sck_q, sck_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0]      led_q, led_d;

    always_comb begin
        phase_d = phase_q ^ pll_tick;
        sck_d   = pll_tick & phase_q;
        pre_d   = pre_q;
        led_d   = led_q;
        // led steps on the pre-increment zero so the first sck_tick is visible at once
        if (sck_q) begin
            pre_d = pre_q + 1'b1;
            if (pre_q == '0) begin
                led_d = led_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            sck_q   <= 1'b0;
            pre_q   <= '0;
            led_q   <= '0;
        end else begin
            phase_q <= phase_d;
            sck_q   <= sck_d;
            pre_q   <= pre_d;
            led_q   <= led_d;
        end
    end

    assign sck_tick = sck_q;
    assign led      = led_q;

endmodule

// File: tb/tb_pll_debug_counter.sv
// Scoreboard bench: expected tick edges and LED change events are queued when
// stimulus is applied and consumed as the three DUT variants produce them.
module tb_pll_debug_counter;

    typedef struct {
        int e;
        int v;
    } ev_t;

    localparam int E1 = 2100;
    localparam int E2 = 2300;
    localparam int E3 = 120;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    logic       lock0, pll0, sck0;
    logic [7:0] led0;
    logic       lock1, pll1, sck1;
    logic [7:0] led1;
    logic       lock2, pll2, sck2;
    logic [7:0] led2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon2 = 1'b1;

    int  q_pll0[$];
    int  q_sck0[$];
    int  q_pll2[$];
    int  q_sck2[$];
    ev_t q_led0[$];
    ev_t q_led1[$];
    ev_t q_led2[$];

    logic [7:0] led0_prev, led1_prev, led2_prev;
    int n_sck0;
    int led1v;

    always #5 clk = ~clk;

    pll_debug_counter u_d0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .pll_lock(lock0), .pll_tick(pll0), .sck_tick(sck0), .led(led0)
    );

    pll_debug_counter #(.PRESCALE_W(3)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .pll_lock(lock1), .pll_tick(pll1), .sck_tick(sck1), .led(led1)
    );

    pll_debug_counter #(.DIVR(0), .DIVF(31), .DIVQ(6), .PRESCALE_W(1), .CNT_W(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .pll_lock(lock2), .pll_tick(pll2), .sck_tick(sck2), .led(led2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Everything expected from a fresh release of rst_n up to edge 'last'.
    task automatic push_fresh(input int last);
        int   n2;
        int   l2;
        ev_t  ev;
        q_pll0.delete(); q_sck0.delete(); q_pll2.delete(); q_sck2.delete();
        q_led0.delete(); q_led1.delete(); q_led2.delete();
        ev.e = 24; ev.v = 1;
        if (last >= 24) q_led0.push_back(ev);
        for (int e = 19; e <= last; e += 3) q_pll0.push_back(e);
        n_sck0 = 0;
        led1v  = 0;
        for (int e = 23; e <= last; e += 6) begin
            q_sck0.push_back(e);
            n_sck0++;
            if (n_sck0 % 8 == 1 && e + 1 <= last) begin
                led1v++;
                ev.e = e + 1; ev.v = led1v;
                q_led1.push_back(ev);
            end
        end
        for (int e = 18; e <= last; e += 2) q_pll2.push_back(e);
        n2 = 0;
        l2 = 0;
        for (int e = 21; e <= last; e += 4) begin
            q_sck2.push_back(e);
            n2++;
            if (n2 % 2 == 1 && e + 1 <= last) begin
                l2 = (l2 + 1) % 256;
                ev.e = e + 1; ev.v = l2;
                q_led2.push_back(ev);
            end
        end
    endtask

    task automatic pop_tick(input string tag, inout int q[$]);
        int e;
        e = (q.size() > 0) ? q.pop_front() : -1;
        chk(tag, cyc, e);
    endtask

    task automatic pop_led(input string tag, inout ev_t q[$], input int val);
        ev_t ev;
        if (q.size() > 0) ev = q.pop_front();
        else begin ev.e = -1; ev.v = -1; end
        chk({tag, "_edge"}, cyc, ev.e);
        chk({tag, "_val"}, val, ev.v);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (pll0) pop_tick("pll0", q_pll0);
        if (sck0) pop_tick("sck0", q_sck0);
        if (led0 !== led0_prev) pop_led("led0", q_led0, int'(led0));
        if (led1 !== led1_prev) pop_led("led1", q_led1, int'(led1));
        if (mon2) begin
            if (pll2) pop_tick("pll2", q_pll2);
            if (sck2) pop_tick("sck2", q_sck2);
            if (led2 !== led2_prev) pop_led("led2", q_led2, int'(led2));
        end
        led0_prev = led0;
        led1_prev = led1;
        led2_prev = led2;
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_pll0_left"}, q_pll0.size(), 0);
        chk({tag, "_sck0_left"}, q_sck0.size(), 0);
        chk({tag, "_led0_left"}, q_led0.size(), 0);
        chk({tag, "_led1_left"}, q_led1.size(), 0);
        if (mon2) begin
            chk({tag, "_pll2_left"}, q_pll2.size(), 0);
            chk({tag, "_sck2_left"}, q_sck2.size(), 0);
            chk({tag, "_led2_left"}, q_led2.size(), 0);
        end
    endtask

    task automatic lock_check();
        chk("lock0", int'(lock0), (cyc >= 16) ? 1 : 0);
        chk("lock1", int'(lock1), (cyc >= 16) ? 1 : 0);
        chk("lock2", int'(lock2), (cyc >= 16) ? 1 : 0);
    endtask

    initial begin
        int   n_pll0;
        int   n_sck0_win;
        ev_t  ev;

        en    = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        led0_prev = 8'h00;
        led1_prev = 8'h00;
        led2_prev = 8'h00;
        repeat (3) step();
        chk("rst_lock0", int'(lock0), 0);
        chk("rst_pll0",  int'(pll0),  0);
        chk("rst_sck0",  int'(sck0),  0);
        chk("rst_led0",  int'(led0),  0);
        chk("rst_led1",  int'(led1),  0);
        chk("rst_led2",  int'(led2),  0);

        // release and free-run with en high
        push_fresh(E1);
        rst_n = 1'b1;
        cyc   = 0;
        n_pll0     = 0;
        n_sck0_win = 0;
        while (cyc < E1) begin
            step();
            if (cyc <= 20) lock_check();
            if (cyc >= 17 && cyc <= 616 && pll0) n_pll0++;
            if (cyc >= 17 && cyc <= 622 && sck0) n_sck0_win++;
        end
        chk("pll0_count_600", n_pll0, 200);
        chk("sck0_count", n_sck0_win, 100);
        check_drained("run");

        // en low for 10 edges; the ratio must resume exactly where it froze
        mon2 = 1'b0;
        en   = 1'b0;
        for (int e = 2111; e <= E2; e += 3) q_pll0.push_back(e);
        for (int e = 2115; e <= E2; e += 6) begin
            q_sck0.push_back(e);
            n_sck0++;
            if (n_sck0 % 8 == 1 && e + 1 <= E2) begin
                led1v++;
                ev.e = e + 1; ev.v = led1v;
                q_led1.push_back(ev);
            end
        end
        while (cyc < E2) begin
            step();
            if (cyc >= 2101 && cyc <= 2110) begin
                chk("en_low_pll2", int'(pll2), 0);
                chk("en_low_pll1", int'(pll1), 0);
                chk("en_low_sck1", int'(sck1), 0);
                chk("en_low_led1", int'(led1), 44);
            end
            if (cyc == 2110) en = 1'b1;
        end
        check_drained("en_gap");

        // asynchronous reset mid-run
        #3 rst_n = 1'b0;
        #1;
        chk("async_lock0", int'(lock0), 0);
        chk("async_pll0",  int'(pll0),  0);
        chk("async_sck0",  int'(sck0),  0);
        chk("async_led0",  int'(led0),  0);
        chk("async_led1",  int'(led1),  0);
        chk("async_pll2",  int'(pll2),  0);
        chk("async_sck2",  int'(sck2),  0);
        chk("async_led2",  int'(led2),  0);
        led0_prev = led0;
        led1_prev = led1;
        led2_prev = led2;
        repeat (2) step();
        mon2 = 1'b1;
        push_fresh(E3);
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < E3) begin
            step();
            if (cyc <= 20) lock_check();
        end
        chk("relock_led1", int'(led1), 3);
        check_drained("relock");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
